tick_ser_tx: RTL



---
 rtl/tick_ser_tx_if.sv | 15 +
 rtl/tick_ser_tx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/tick_ser_tx_if.sv
// tick_ser_tx_if: parallel-word handshake feeding tick_ser_tx.
//   in_data  [DATA_W]  word to send, sampled when the word is accepted
//   in_valid           upstream has a word
//   in_ready           transmitter can accept (high only while idle)
// modport master: upstream side; modport slave: transmitter side.
interface tick_ser_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/tick_ser_tx.sv
// tick_ser_tx: tick-paced asynchronous-serial transmitter.
// Frame = start (0), DATA_W data bits LSB first, [even parity], STOP_BITS
// stop bits (1). Every bit lasts one tick period; tx only moves on tick.
// Optional even parity bit: build with macro TICK_SER_TX_PARITY_EN.
// Ports:
//   clk    system clock, posedge
//   rst    asynchronous active-high reset
//   tick   one-cycle bit-time strobe from the clock divider
//   in_if  handshake (slave modport): in_data, in_valid, in_ready
//   tx     registered serial line, idles high
//   busy   high from the cycle after acceptance until back in IDLE
//   done   one-cycle pulse on the first IDLE cycle after a frame
//
// state  | meaning
// IDLE   | line high, in_ready high, waiting for a word
// PEND   | word latched, waiting for first tick to drive the start bit
// START  | start bit on the line
// DATA   | data bit bit_cnt on the line
// PARITY | even-parity bit on the line (parity build only)
// STOP   | stop bit stop_cnt on the line
module tick_ser_tx #(
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    tick_ser_tx_if.slave in_if,
    output logic         tx,
    output logic         busy,
    output logic         done
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic LAST_STOP = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PEND,
        S_START,
        S_DATA,
`ifdef TICK_SER_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] sh, sh_nxt;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic              stop_cnt, stop_cnt_nxt;
    logic              tx_nxt, busy_nxt, done_nxt;
`ifdef TICK_SER_TX_PARITY_EN
    // The shift register is consumed as bits go out, so parity of the
    // original word is captured at acceptance.
    logic              par, par_nxt;
`endif

    assign in_if.in_ready = (state == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            sh       <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef TICK_SER_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            sh       <= sh_nxt;
            bit_cnt  <= bit_cnt_nxt;
            stop_cnt <= stop_cnt_nxt;
            tx       <= tx_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
`ifdef TICK_SER_TX_PARITY_EN
            par      <= par_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt    = state;
        sh_nxt       = sh;
        bit_cnt_nxt  = bit_cnt;
        stop_cnt_nxt = stop_cnt;
        tx_nxt       = tx;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
`ifdef TICK_SER_TX_PARITY_EN
        par_nxt      = par;
`endif
        case (state)
            S_IDLE: begin
                // tick is deliberately ignored here, including on the
                // accept cycle: the start bit waits for the next tick.
                if (in_if.in_valid) begin
                    sh_nxt    = in_if.in_data;
                    busy_nxt  = 1'b1;
                    state_nxt = S_PEND;
`ifdef TICK_SER_TX_PARITY_EN
                    par_nxt   = ^in_if.in_data;
`endif
                end
            end
            S_PEND: begin
                if (tick) begin
                    tx_nxt    = 1'b0;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    tx_nxt      = sh[0];
                    sh_nxt      = {1'b0, sh[DATA_W-1:1]};
                    bit_cnt_nxt = '0;
                    state_nxt   = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_cnt == LAST_BIT) begin
`ifdef TICK_SER_TX_PARITY_EN
                        tx_nxt       = par;
                        state_nxt    = S_PARITY;
`else
                        tx_nxt       = 1'b1;
                        stop_cnt_nxt = 1'b0;
                        state_nxt    = S_STOP;
`endif
                    end else begin
                        tx_nxt      = sh[0];
                        sh_nxt      = {1'b0, sh[DATA_W-1:1]};
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end
                end
            end
`ifdef TICK_SER_TX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    tx_nxt       = 1'b1;
                    stop_cnt_nxt = 1'b0;
                    state_nxt    = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (stop_cnt == LAST_STOP) begin
                        stop_cnt_nxt = 1'b0;
                        busy_nxt     = 1'b0;
                        done_nxt     = 1'b1;
                        state_nxt    = S_IDLE;
                    end else begin
                        stop_cnt_nxt = 1'b1;
                    end
                end
            end
            default: begin
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end
endmodule
